// File: rtl/axi_slave_mem_pkg.sv
// Shared AXI constants and FSM state types for the slave memory and the
// axi_master channel logic.
package axi_slave_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   // Only FIXED and INCR are served; WRAP and the reserved code error out.
   function automatic logic burst_supported(input logic [1:0] burst);
      logic ok;
      case (burst)
         BURST_FIXED: ok = 1'b1;
         BURST_INCR:  ok = 1'b1;
         BURST_WRAP:  ok = 1'b0;
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/axi_slave_mem_array.sv
// Word-wide storage: one write port and one registered read port.
// The read register only updates when i_rd_en is high, so the value held
// on o_rd_data stays put while the read channel is stalled.
module axi_slave_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int AW         = 10
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [AW-1:0]         i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [AW-1:0]         i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Write port
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read; a same-edge write to this word is seen next time
   always_ff @(posedge clk) begin
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI burst slave in front of a word-addressed memory. Independent read and
// write FSMs; FIXED/INCR bursts only; out-of-range beats answer SLVERR.
module axi_slave_mem
   import axi_slave_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 8,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  ARVALID,
   input  logic [BURST_LEN-1:0]  ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  AWVALID,
   input  logic [BURST_LEN-1:0]  AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic                  rd_busy,
   output logic                  wr_busy
);

   localparam int SHIFT  = $clog2(DATA_WIDTH / 8);
   localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [2:0]            SIZE_NATIVE = 3'(SHIFT);
   localparam logic [ADDR_WIDTH-1:0] DEPTH       = ADDR_WIDTH'(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE     = ADDR_WIDTH'(1);
   localparam logic [BURST_LEN-1:0]  CNT_ONE     = BURST_LEN'(1);

   // ---------------- read channel ----------------
   rd_state_t               r_rstate, w_rstate_next;
   logic [ADDR_WIDTH-1:0]   r_ridx;
   logic [BURST_LEN-1:0]    r_rcnt;      // beats left after the one on RDATA
   logic [1:0]              r_rburst;
   logic                    r_rerr;      // whole burst is illegal
   logic                    r_rzero;     // current beat has no valid word
   logic [1:0]              r_rresp;
   logic                    r_rlast;

   logic                    w_ar_hs, w_r_adv, w_r_done, w_ar_err, w_rd_err, w_rd_en;
   logic [ADDR_WIDTH-1:0]   w_rd_idx;
   logic [DATA_WIDTH-1:0]   w_ram_q;

   assign w_ar_hs  = (r_rstate == R_IDLE) && ARVALID;
   assign w_r_adv  = (r_rstate == R_DATA) && RREADY && !r_rlast;
   assign w_r_done = (r_rstate == R_DATA) && RREADY && r_rlast;
   assign w_ar_err = !burst_supported(ARBURST) || (ARSIZE != SIZE_NATIVE);

   // The RAM is addressed with the beat that will sit on RDATA next cycle.
   assign w_rd_idx = w_ar_hs ? (ARADDR >> SHIFT)
                   : ((r_rburst == BURST_FIXED) ? r_ridx : r_ridx + IDX_ONE);
   assign w_rd_err = (w_ar_hs ? w_ar_err : r_rerr) || (w_rd_idx >= DEPTH);
   assign w_rd_en  = (w_ar_hs || w_r_adv) && !w_rd_err;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_next;
   end

   // Read FSM next state
   always_comb begin
      w_rstate_next = r_rstate;
      case (r_rstate)
         R_IDLE:  if (ARVALID) w_rstate_next = R_DATA;
         R_DATA:  if (RREADY && r_rlast) w_rstate_next = R_IDLE;
         default: w_rstate_next = R_IDLE;
      endcase
   end

   // Read burst bookkeeping and per-beat response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ridx   <= '0;
         r_rcnt   <= '0;
         r_rburst <= BURST_FIXED;
         r_rerr   <= 1'b0;
         r_rzero  <= 1'b1;
         r_rresp  <= RESP_OKAY;
         r_rlast  <= 1'b0;
      end else if (w_ar_hs) begin
         r_ridx   <= w_rd_idx;
         r_rcnt   <= ARLEN;
         r_rburst <= ARBURST;
         r_rerr   <= w_ar_err;
         r_rzero  <= w_rd_err;
         r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
         r_rlast  <= (ARLEN == '0);
      end else if (w_r_adv) begin
         r_ridx   <= w_rd_idx;
         r_rcnt   <= r_rcnt - CNT_ONE;
         r_rzero  <= w_rd_err;
         r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
         r_rlast  <= (r_rcnt == CNT_ONE);
      end else if (w_r_done) begin
         r_rlast  <= 1'b0;
      end
   end

   assign ARREADY = (r_rstate == R_IDLE);
   assign RVALID  = (r_rstate == R_DATA);
   assign RDATA   = r_rzero ? '0 : w_ram_q;
   assign RRESP   = r_rresp;
   assign RLAST   = r_rlast;
   assign rd_busy = (r_rstate != R_IDLE);

   // ---------------- write channel ----------------
   wr_state_t               r_wstate, w_wstate_next;
   logic [ADDR_WIDTH-1:0]   r_widx;
   logic [BURST_LEN-1:0]    r_wcnt;      // beats left after the current one
   logic [1:0]              r_wburst;
   logic                    r_werr;      // whole burst is illegal
   logic                    r_wacc;      // some earlier beat erred
   logic [1:0]              r_bresp;

   logic                    w_aw_hs, w_w_hs, w_w_final, w_aw_err, w_w_oor, w_beat_err, w_wr_en;

   assign w_aw_hs    = (r_wstate == W_IDLE) && AWVALID;
   assign w_w_hs     = (r_wstate == W_DATA) && WVALID;
   assign w_w_final  = (r_wcnt == '0);
   assign w_aw_err   = !burst_supported(AWBURST) || (AWSIZE != SIZE_NATIVE);
   assign w_w_oor    = (r_widx >= DEPTH);
   // A misplaced WLAST flags the response but does not block the write.
   assign w_beat_err = r_werr || w_w_oor || (WLAST != w_w_final);
   assign w_wr_en    = w_w_hs && !r_werr && !w_w_oor;

   // Write FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_next;
   end

   // Write FSM next state; the beat count alone ends the data phase
   always_comb begin
      w_wstate_next = r_wstate;
      case (r_wstate)
         W_IDLE:  if (AWVALID) w_wstate_next = W_DATA;
         W_DATA:  if (WVALID && w_w_final) w_wstate_next = W_RESP;
         W_RESP:  if (BREADY) w_wstate_next = W_IDLE;
         default: w_wstate_next = W_IDLE;
      endcase
   end

   // Write burst bookkeeping and error accumulation into BRESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_widx   <= '0;
         r_wcnt   <= '0;
         r_wburst <= BURST_FIXED;
         r_werr   <= 1'b0;
         r_wacc   <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_aw_hs) begin
         r_widx   <= AWADDR >> SHIFT;
         r_wcnt   <= AWLEN;
         r_wburst <= AWBURST;
         r_werr   <= w_aw_err;
         r_wacc   <= 1'b0;
      end else if (w_w_hs) begin
         r_wacc <= r_wacc || w_beat_err;
         if (w_w_final) begin
            r_bresp <= (r_wacc || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
         end else begin
            r_wcnt <= r_wcnt - CNT_ONE;
            if (r_wburst != BURST_FIXED) r_widx <= r_widx + IDX_ONE;
         end
      end
   end

   assign AWREADY = (r_wstate == W_IDLE);
   assign WREADY  = (r_wstate == W_DATA);
   assign BVALID  = (r_wstate == W_RESP);
   assign BRESP   = r_bresp;
   assign wr_busy = (r_wstate != W_IDLE);

   // ---------------- storage ----------------
   axi_slave_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .AW         (MEM_AW)
   ) u_array (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_widx[MEM_AW-1:0]),
      .i_wr_data (WDATA),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_idx[MEM_AW-1:0]),
      .o_rd_data (w_ram_q)
   );

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 32, byte address width.
- DATA_WIDTH, default 32, bits per beat (byte-multiple).
- BURST_LEN, default 8, width of AxLEN.
- MEM_WORDS, default 1024, memory depth in DATA_WIDTH words.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, reset; synchronous and active-high.
- ARADDR, in, ADDR_WIDTH, read start byte address.
- ARVALID, in, 1, read address valid.
- ARLEN, in, BURST_LEN, read beats minus one.
- ARSIZE, in, 3, read beat size.
- ARBURST, in, 2, read burst type.
- ARREADY, out, 1, read address accept.
- RDATA, out, DATA_WIDTH, read data.
- RRESP, out, 2, read beat response.
- RLAST, out, 1, final read beat.
- RVALID, out, 1, read data valid.
- RREADY, in, 1, master accepts read beat.
- AWADDR, in, ADDR_WIDTH, write start byte address.
- AWVALID, in, 1, write address valid.
- AWLEN, in, BURST_LEN, write beats minus one.
- AWSIZE, in, 3, write beat size.
- AWBURST, in, 2, write burst type.
- AWREADY, out, 1, write address accept.
- WDATA, in, DATA_WIDTH, write data.
- WLAST, in, 1, master's final-beat flag.
- WVALID, in, 1, write data valid.
- WREADY, out, 1, write data accept.
- BRESP, out, 2, write response.
- BVALID, out, 1, write response valid.
- BREADY, in, 1, master accepts response.
- rd_busy, out, 1, read burst in progress.
- wr_busy, out, 1, write burst in progress.

Function
REQ-003 Transfers SHALL use the handshake rule: a beat transfers when VALID and READY are both high on a rising edge; outputs SHALL hold stable while VALID is high and READY is low.
REQ-004 The read FSM SHALL have states R_IDLE and R_DATA; ARREADY SHALL be high only in R_IDLE.
REQ-005 An AR handshake in cycle N SHALL latch address, beat count ARLEN+1, burst type and error flag, move to R_DATA and assert RVALID in cycle N+1 with the first beat's data.
REQ-006 In R_DATA, each accepted beat SHALL load the next beat's data into RDATA so that beats stream back-to-back; RLAST SHALL be high only on beat ARLEN+1.
REQ-007 Acceptance of the RLAST beat SHALL return the read FSM to R_IDLE, with ARREADY high in the next cycle.
REQ-008 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- AWREADY SHALL be high only in W_IDLE.
- WREADY SHALL be high only in W_DATA.
- BVALID SHALL be high only in W_RESP.
REQ-009 Each accepted W beat SHALL write WDATA to the current word; the write FSM SHALL leave W_DATA after exactly AWLEN+1 beats, regardless of WLAST.
REQ-010 A WLAST value that does not match the final-beat position SHALL set BRESP to SLVERR (2'b10); memory writes SHALL still occur.
REQ-011 A B handshake SHALL return the write FSM to W_IDLE.
REQ-012 Word index SHALL be byte address >> log2(DATA_WIDTH/8), with the low bits ignored.
- INCR (2'b01) SHALL add 1 per beat.
- FIXED (2'b00) SHALL hold the address constant.
- Index arithmetic SHALL be ADDR_WIDTH wide with no wrap into the array.
REQ-013 A beat whose index is >= MEM_WORDS SHALL return SLVERR (RDATA 0, or write suppressed); other beats SHALL return OKAY (2'b00).
REQ-014 WRAP (2'b10), reserved (2'b11) burst types, or AxSIZE != log2(DATA_WIDTH/8) SHALL cause:
- SLVERR on every beat.
- No memory write.
- Full beat count still honoured.
REQ-015 BRESP SHALL be SLVERR if any beat of the burst erred.
REQ-016 The read and write FSMs SHALL operate concurrently; a same-cycle read and write to one word SHALL return the old data.
REQ-017 rd_busy SHALL equal (state != R_IDLE); wr_busy SHALL equal (state != W_IDLE).

Reset
REQ-018 When rst is high, on the next clk edge:
- Both FSMs SHALL go idle.
- ARREADY and AWREADY SHALL be 1.
- RVALID, RLAST, WREADY, BVALID, rd_busy and wr_busy SHALL be 0.
- RDATA, RRESP and BRESP SHALL be 0.
REQ-019 Memory contents SHALL NOT be cleared by reset; a reset mid-burst SHALL abandon the burst with no response issued.

Structure
REQ-020 A shared package SHALL hold the RESP_OKAY/RESP_SLVERR and BURST_FIXED/INCR/WRAP constants, for reuse by axi_master's channels.
REQ-021 The storage SHALL be one sub-module, axi_slave_mem_array (1 write port, 1 registered read port).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read INCR at 0x10, ARLEN=3, RREADY=1 -> ARREADY low 4 cycles; RDATA=mem[4..7] on consecutive cycles; RLAST on the 4th; RRESP=0.
- Write INCR at 0x0, AWLEN=7, data 0xA0..0xA7 with WVALID gaps -> mem[0..7]=0xA0..0xA7; one BVALID with BRESP=0, held until BREADY.
- Read of 2 beats with RREADY toggled 1,0,0,1 -> RDATA/RLAST stable during stall; exactly 2 beats.
- Write at word MEM_WORDS-1, AWLEN=1 -> first word written; second suppressed; BRESP=2'b10.
- Concurrent read and write to word 5 in the same cycle; then ARBURST=WRAP -> old value returned; WRAP beats all SLVERR.
- rst mid-write after 2 of 4 beats -> wr_busy=0 and BVALID=0 next cycle; first 2 words retain new data.
